mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Round-robin arbiter sharing one single-port, synchronous-read SRAM (we/ce/addr/din/dout, 1-cycle read latency, write has priority over read, dout unchanged on write) between NUM_REQ requesters. It accepts at most one request per cycle with a valid/ready handshake. It registers the winning command onto the SRAM pins and returns read data tagged to the originating requester. It sits between the compute-side masters and the SRAM macro wrapper.

## Interface
- NUM_REQ, 2: number of requesters (2..8).
- ADDR_WIDTH, 8: SRAM address width.
- DATA_WIDTH, 16: SRAM data width.
- clk  in  1  single clock, all logic on posedge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  one-hot grant; a transfer occurs when req_valid[i] & req_ready[i].
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened; requester i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_REQ*DATA_WIDTH  flattened write data, same slicing.
- rsp_valid  out  NUM_REQ  one-hot read-data strobe, one cycle per accepted read.
- rsp_rdata  out  DATA_WIDTH  read data, shared; valid only while any rsp_valid bit is high.
- mem_ce, mem_we  out  1  registered SRAM enables.
- mem_addr  out  ADDR_WIDTH  registered SRAM address.
- mem_din  out  DATA_WIDTH  registered SRAM write data.
- mem_dout  in  DATA_WIDTH  SRAM read data.

## Operation
- Arbitration: round-robin over req_valid. The search starts at index ptr, ascending with wrap. The first valid index wins, and req_ready is asserted for that index only. ptr is ptr_next = winner+1, wrapping NUM_REQ-1 → 0, and updates only on a grant.
- req_ready is combinational from req_valid and ptr. It is all-zero when no valid or during reset. Requesters must hold valid/we/addr/wdata stable until accepted.
- Issue stage (S1): on grant, mem_ce←1, mem_we←req_we[w], mem_addr/mem_din←slices of w. The requester id and an is_read bit are stored with the command. With no grant, mem_ce←0, mem_we←0, and addr/din hold their previous values.
- Return stage (S2): if S1 held a read, S2 captures its id on the following edge. In that cycle rsp_valid[id]=1 and rsp_rdata=mem_dout, passed through combinationally.
- Writes generate no response.
- Responses have no backpressure; requesters must always sink rsp_valid.
- Ordering: strictly in issue order, one command per cycle. A read accepted the cycle after a write to the same address returns the new data.
- Full throughput: back-to-back grants every cycle, with no bubbles between requesters.

## Timing
- Reset (rst_n=0, asynchronous) clears:
  - mem_ce=0, mem_we=0, mem_addr=0, mem_din=0
  - ptr=0 (requester 0 highest priority)
  - S1/S2 valid bits =0, so rsp_valid=0 and req_ready=0
  - rsp_rdata is don't-care
- Read accepted in cycle N: mem_ce=1 during N+1, SRAM samples at end of N+1, rsp_valid high during N+2. Latency 2 cycles from handshake to data.
- Write accepted in cycle N: committed at end of cycle N+1.
- Simultaneous valids: exactly one grant per cycle. With all NUM_REQ requesters continuously valid, each is granted once every NUM_REQ cycles.
- A single requester continuously valid is granted every cycle.
- Reset mid-operation: in-flight S1/S2 commands are dropped. Reads issue no rsp_valid. A write still in S1 is not performed, because mem_ce is cleared asynchronously before the edge.
- First grant after reset release goes to the lowest valid index.

## Structure
- Shared package mem_arb_pkg: ID_W = clog2(NUM_REQ) (min 1), default widths, and the slice-index helper for the flattened buses.
- Sub-module rr_arbiter (NUM_REQ): inputs req_valid and the grant-taken strobe; outputs a one-hot grant and a binary winner id. It owns the ptr register with asynchronous reset.
- mem_arbiter instantiates rr_arbiter and holds the S1/S2 pipeline registers and the response demux.

## Test plan
- Reset check: assert rst_n=0 mid-traffic with a read in S2 → rsp_valid=0 immediately, mem_ce=0. After release with all req_valid=1, the first grant goes to req_ready=2'b01.
- Single read/write: req0 writes 0xBEEF to addr 0x10 in cycle N. req0 reads 0x10 in N+1 → rsp_valid=2'b01 with rsp_rdata=0xBEEF in cycle N+3.
- Fairness: both requesters valid for 8 cycles → grants alternate 01,10,01,…, four each, with mem_ce=1 every cycle.
- Cross-requester hazard: req1 writes 0x1234 to addr 0xFF. req0 reads 0xFF on the next cycle → rsp_valid=2'b01 with 0x1234.
- Hold stability: req1 valid while req0 is granted → req_ready[1]=0 that cycle and req_ready[1]=1 the next, with the address unchanged on mem_addr.
- Pointer wrap with NUM_REQ=4 and only req3 and req0 valid → grants go 0,3,0,3. No grant is issued to an idle index.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the round-robin SRAM arbiter.
// Widths here are defaults; modules recompute ID_W from NUM_REQ.
package mem_arb_pkg;

    localparam int DEF_NUM_REQ    = 2;
    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 16;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

    localparam int ID_W = id_w(DEF_NUM_REQ);

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side bus: flattened request handshake plus tagged read return.
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            req_we;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]         rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin picker: search starts at ptr, ascending with wrap.
// ptr moves to winner+1 only when a grant is taken.
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    localparam int IW      = id_w(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic               take,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      win
);
    logic [IW-1:0] ptr;
    logic [IW:0]   idx;
    logic          found;

    always_comb begin
        grant = '0;
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = {1'b0, ptr} + (IW+1)'(i);
            if (idx >= (IW+1)'(NUM_REQ))
                idx = idx - (IW+1)'(NUM_REQ);
            if (!found && rst_n && req_valid[idx[IW-1:0]]) begin
                found = 1'b1;
                win   = idx[IW-1:0];
            end
        end
        if (found)
            grant[win] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= '0;
        else if (take)
            ptr <= (win == IW'(NUM_REQ-1)) ? '0 : win + 1'b1;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous-read SRAM among NUM_REQ requesters.
// S1 drives the SRAM pins, S2 tags the returning read data.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mem_arbiter_if.slave          bus,
    output logic                  mem_ce,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout
);
    localparam int IW = id_w(NUM_REQ);

    logic [NUM_REQ-1:0] grant;
    logic [IW-1:0]      win;
    logic               take;
    logic [IW-1:0]      s1_id;
    op_e                s1_op;
    logic               s2_vld;
    logic [IW-1:0]      s2_id;
    logic [NUM_REQ-1:0] rsp_vec;

    assign take          = |grant;
    assign bus.req_ready = grant;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (bus.req_valid),
        .take      (take),
        .grant     (grant),
        .win       (win)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_ce   <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
            s1_id    <= '0;
            s1_op    <= OP_READ;
        end else if (take) begin
            mem_ce   <= 1'b1;
            mem_we   <= bus.req_we[win];
            mem_addr <= bus.req_addr[slice_lo(int'(win), ADDR_WIDTH) +: ADDR_WIDTH];
            mem_din  <= bus.req_wdata[slice_lo(int'(win), DATA_WIDTH) +: DATA_WIDTH];
            s1_id    <= win;
            s1_op    <= bus.req_we[win] ? OP_WRITE : OP_READ;
        end else begin
            // addr/din hold so the SRAM pins stay quiet when idle
            mem_ce <= 1'b0;
            mem_we <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld <= 1'b0;
            s2_id  <= '0;
        end else begin
            s2_vld <= mem_ce && (s1_op == OP_READ);
            s2_id  <= s1_id;
        end
    end

    always_comb begin
        rsp_vec = '0;
        if (s2_vld)
            rsp_vec[s2_id] = 1'b1;
    end

    assign bus.rsp_valid = rsp_vec;
    assign bus.rsp_rdata = mem_dout;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, random traffic against a
// queue-based reference model, and a mid-traffic reset sequence.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          mem_ce;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;

    always #5 clk = ~clk;

    mem_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .mem_ce   (mem_ce),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_dout (mem_dout)
    );

    // SRAM macro: 1-cycle read, write wins, dout held on write
    logic [DW-1:0] sram [256];
    always @(posedge clk) begin
        if (mem_ce) begin
            if (mem_we) sram[mem_addr] <= mem_din;
            else        mem_dout <= sram[mem_addr];
        end
    end

    typedef struct {
        int            due;
        int            id;
        logic [DW-1:0] data;
    } rsp_t;

    typedef struct {
        logic [N-1:0]    v;
        logic [N-1:0]    we;
        logic [N*AW-1:0] a;
        logic [N*DW-1:0] d;
        logic [N-1:0]    rdy;
        logic [N-1:0]    rv;
        logic [DW-1:0]   rd;
    } vec_t;

    rsp_t          pend [$];
    logic [DW-1:0] mem_m [256];
    int            ptr_m;
    int            cyc;
    logic [N-1:0]  gnt_m;
    logic          e_ce, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din;
    int            n_chk = 0;
    int            n_pass = 0;
    vec_t          tbl [25];
    vec_t          nil;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    function automatic logic [N-1:0] rr_pick(input logic [N-1:0] v, input int p);
        logic [N-1:0] g;
        g = '0;
        for (int k = 0; k < N; k++) begin
            if (g == '0 && v[(p + k) % N]) g[(p + k) % N] = 1'b1;
        end
        return g;
    endfunction

    task automatic model_reset();
        ptr_m = 0;
        pend.delete();
        e_ce = 1'b0;
        e_we = 1'b0;
        e_addr = '0;
        e_din = '0;
        gnt_m = '0;
    endtask

    task automatic tick(input bit use_tv, input vec_t tv, input int k);
        logic [N-1:0]  exp_rv;
        logic [DW-1:0] exp_rd;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        rsp_t          r;
        @(negedge clk);
        gnt_m = rr_pick(bus.req_valid, ptr_m);
        chk("req_ready", 64'(bus.req_ready), 64'(gnt_m));
        exp_rv = '0;
        exp_rd = '0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            r = pend.pop_front();
            exp_rv[r.id] = 1'b1;
            exp_rd = r.data;
        end
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(exp_rv));
        if (exp_rv != '0) chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(exp_rd));
        chk("mem_ce", 64'(mem_ce), 64'(e_ce));
        chk("mem_we", 64'(mem_we), 64'(e_we));
        chk("mem_addr", 64'(mem_addr), 64'(e_addr));
        chk("mem_din", 64'(mem_din), 64'(e_din));
        if (use_tv) begin
            chk($sformatf("tv_rdy[%0d]", k), 64'(bus.req_ready), 64'(tv.rdy));
            chk($sformatf("tv_rv[%0d]", k), 64'(bus.rsp_valid), 64'(tv.rv));
            if (tv.rv != '0)
                chk($sformatf("tv_rd[%0d]", k), 64'(bus.rsp_rdata), 64'(tv.rd));
        end
        e_ce = 1'b0;
        e_we = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (gnt_m[i]) begin
                a = bus.req_addr[i*AW +: AW];
                d = bus.req_wdata[i*DW +: DW];
                e_ce = 1'b1;
                e_we = bus.req_we[i];
                e_addr = a;
                e_din = d;
                if (bus.req_we[i]) mem_m[a] = d;
                else pend.push_back('{cyc + 2, i, mem_m[a]});
                ptr_m = (i + 1) % N;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.req_valid = '0;
        for (int i = 0; i < n; i++) tick(1'b0, nil, 0);
    endtask

    initial begin
        nil = '{'0, '0, '0, '0, '0, '0, '0};
        for (int i = 0; i < 256; i++) begin
            sram[i]  = 16'hA000 + 16'(i);
            mem_m[i] = 16'hA000 + 16'(i);
        end

        tbl[0]  = '{4'b0001, 4'b0001, 32'h00000010, 64'h000000000000BEEF, 4'b0001, 4'b0000, 16'h0};
        tbl[1]  = '{4'b0001, 4'b0000, 32'h00000010, 64'h0, 4'b0001, 4'b0000, 16'h0};
        tbl[2]  = '{4'b0000, 4'b0000, 32'h0, 64'h0, 4'b0000, 4'b0000, 16'h0};
        tbl[3]  = '{4'b0000, 4'b0000, 32'h0, 64'h0, 4'b0000, 4'b0001, 16'hBEEF};
        for (int k = 4; k < 12; k++)
            tbl[k] = '{4'b0011, 4'b0000, 32'h00002120, 64'h0,
                       (k % 2 == 0) ? 4'b0010 : 4'b0001,
                       (k < 6) ? 4'b0000 : ((k % 2 == 0) ? 4'b0010 : 4'b0001),
                       (k % 2 == 0) ? 16'hA021 : 16'hA020};
        tbl[12] = '{4'b0010, 4'b0010, 32'h0000FF00, 64'h0000000012340000, 4'b0010, 4'b0010, 16'hA021};
        tbl[13] = '{4'b0001, 4'b0000, 32'h000000FF, 64'h0, 4'b0001, 4'b0001, 16'hA020};
        tbl[14] = '{4'b0010, 4'b0000, 32'h00004000, 64'h0, 4'b0010, 4'b0000, 16'h0};
        tbl[15] = '{4'b0011, 4'b0000, 32'h00003130, 64'h0, 4'b0001, 4'b0001, 16'h1234};
        tbl[16] = '{4'b0010, 4'b0000, 32'h00003130, 64'h0, 4'b0010, 4'b0010, 16'hA040};
        tbl[17] = '{4'b0000, 4'b0000, 32'h0, 64'h0, 4'b0000, 4'b0001, 16'hA030};
        tbl[18] = '{4'b0000, 4'b0000, 32'h0, 64'h0, 4'b0000, 4'b0010, 16'hA031};
        for (int k = 19; k < 23; k++)
            tbl[k] = '{4'b1001, 4'b0000, 32'h53000050, 64'h0,
                       (k % 2 == 1) ? 4'b1000 : 4'b0001,
                       (k == 21) ? 4'b1000 : ((k == 22) ? 4'b0001 : 4'b0000),
                       (k == 21) ? 16'hA053 : 16'hA050};
        tbl[23] = '{4'b0000, 4'b0000, 32'h0, 64'h0, 4'b0000, 4'b1000, 16'hA053};
        tbl[24] = '{4'b0000, 4'b0000, 32'h0, 64'h0, 4'b0000, 4'b0001, 16'hA050};

        rst_n = 1'b0;
        bus.req_valid = '1;
        bus.req_we = '0;
        bus.req_addr = '0;
        bus.req_wdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(bus.req_ready), 64'h0);
        chk("rst_rsp", 64'(bus.rsp_valid), 64'h0);
        chk("rst_ce", 64'(mem_ce), 64'h0);
        chk("rst_we", 64'(mem_we), 64'h0);
        chk("rst_addr", 64'(mem_addr), 64'h0);
        chk("rst_din", 64'(mem_din), 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        cyc = 0;

        for (int k = 0; k < 25; k++) begin
            bus.req_valid = tbl[k].v;
            bus.req_we    = tbl[k].we;
            bus.req_addr  = tbl[k].a;
            bus.req_wdata = tbl[k].d;
            tick(1'b1, tbl[k], k);
        end

        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!bus.req_valid[i] || gnt_m[i]) begin
                    bus.req_valid[i] = ($urandom_range(0, 99) < ((c < 1000) ? 95 : 50));
                    bus.req_we[i] = ($urandom_range(0, 2) == 0);
                    bus.req_addr[i*AW +: AW] = AW'($urandom_range(0, 15));
                    bus.req_wdata[i*DW +: DW] = DW'($urandom);
                end
            end
            tick(1'b0, nil, 0);
        end
        idle(4);

        // reads of 0x60 (in S2) and 0x61 (in S1) when reset hits
        bus.req_valid = 4'b0001;
        bus.req_we = '0;
        bus.req_addr = 32'h00000060;
        tick(1'b0, nil, 0);
        bus.req_addr = 32'h00000061;
        tick(1'b0, nil, 0);
        bus.req_valid = '0;
        chk("pre_rst_rsp", 64'(bus.rsp_valid), 64'h1);
        bus.req_valid = '1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rsp", 64'(bus.rsp_valid), 64'h0);
        chk("mid_rst_ce", 64'(mem_ce), 64'h0);
        chk("mid_rst_ready", 64'(bus.req_ready), 64'h0);
        model_reset();
        @(negedge clk);
        chk("mid_rst_ready2", 64'(bus.req_ready), 64'h0);
        @(posedge clk);
        #1;
        chk("mid_rst_ce2", 64'(mem_ce), 64'h0);
        rst_n = 1'b1;
        #1;
        chk("first_grant", 64'(bus.req_ready), 64'h1);
        for (int k = 0; k < 8; k++) tick(1'b0, nil, 0);
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
